plc_prg: RTL and testbench
==========================

# plc_prg

Single-channel PLC-style spindle/feed control block for the lathe retrofit, built as a Tiny Tapeout user tile. It selects between AUTO mode and MANUAL mode from two selector inputs. In AUTO mode the Control output is driven through an on-delay timer (TON); in MANUAL mode it follows the start input directly. It sits between the operator panel inputs and the lathe contactor/driver output.

## Interface
- TON_PRESET, default 50_000_000 (1 s at 50 MHz), or 20 when SHORT_TIMER_EN is defined: on-delay length in clock cycles. Legal range 1..2^26−1.
- clk  input  1  system clock, 50 MHz nominal; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ui_in  input  8  [0] start, [1] AUTO select, [2] MAN select. [7:3] are ignored.
- uo_out  output  8  [0] Control, [1] timing, [2] auto_active, [3] man_active, [4] mode_conflict. [7:5] are tied to 0.
- uio_in  input  8  ignored.
- uio_out  output  8  tied to 0.
- uio_oe  output  8  tied to 0 (all bidirectional pins are inputs).
- ena  input  1  ignored. The block runs whenever it is out of reset.

## Operation
- Mode decode (combinational):
  - man_active = MAN.
  - auto_active = AUTO & ~MAN. MAN has priority over AUTO.
  - mode_conflict = AUTO & MAN.
  - When both AUTO and MAN are 0, no mode is selected.
- TON accumulator acc, 26-bit, registered:
  - If auto_active & start & acc < TON_PRESET: acc <= acc + 1.
  - Else if auto_active & start: acc holds (saturates at TON_PRESET).
  - Otherwise: acc <= 0. This covers start low, a mode change, MAN asserted, and no mode selected.
- done = (acc == TON_PRESET).
- timing (uo_out[1]) = auto_active & start & ~done.
- Control (uo_out[0]):
  - MANUAL: Control = start, combinational with no clock latency.
  - AUTO: Control = done.
  - No mode selected: Control = 0.
  - While rst = 1, Control is forced to 0 combinationally, including in MANUAL.
- Status outputs [4:2] are combinational decodes of the selector inputs. They are forced to 0 while rst = 1.
- The block has no latching or seal-in. Control never remains high once its enabling condition is gone.

## Timing
- Reset: acc = 0. All uo_out bits read 0 while rst = 1 and immediately after release, until inputs dictate otherwise.
- AUTO on-delay:
  - Control rises on the TON_PRESET-th rising edge at which auto_active & start is sampled high.
  - With TON_PRESET = 20 and start set mid-cycle, Control is high no later than 21 clock periods (420 ns) after start rises.
- AUTO release: start falls → acc clears on the next rising edge → Control falls at that edge (≤1 cycle).
- Start pulse shorter than TON_PRESET cycles in AUTO: Control never asserts, and acc returns to 0.
- Mode changes:
  - AUTO→MAN while timing or done: acc clears at the next edge. Control immediately equals start through the MANUAL path.
  - MAN→AUTO with start held: timing restarts from 0. Control is low until the full delay has elapsed again.
- MANUAL: Control tracks start with only combinational delay in both directions.
- Reset mid-operation: acc clears at once and Control drops at once. After rst falls, AUTO timing restarts from 0 even if start is held.

## Configuration
- SHORT_TIMER_EN:
  - Defined: TON_PRESET = 20 cycles, for simulation.
  - Undefined: TON_PRESET = 50_000_000 cycles (1 s at 50 MHz), for silicon.
  - An explicit parameter override takes precedence in both cases.

## Test plan
- Reset: hold rst = 1 for 50 ns with start = AUTO = 1 → uo_out = 0x00 throughout. After release, Control rises after 20 cycles, not earlier.
- AUTO: AUTO = 1, MAN = 0, start = 1 for 500 ns (SHORT_TIMER_EN) → Control = 0 for cycles 1–19 with timing = 1. Control = 1 from the 20th sampled edge. Drop start → Control = 0 within one cycle.
- AUTO short pulse: start high for 10 cycles → Control stays 0 and acc returns to 0. A following 25-cycle pulse asserts Control after 20 cycles.
- MANUAL: AUTO = 0, MAN = 1, start 0→1 → Control = 1 within 1 ns. start 1→0 → Control = 0 within 1 ns.
- Priority: AUTO = MAN = 1, start pulsed 50 ns → Control follows start immediately, mode_conflict = 1, man_active = 1, auto_active = 0.
- No mode: AUTO = MAN = 0, start = 1 for 100 ns → Control = 0, timing = 0, uo_out = 0x00.

Source files
------------

// File: rtl/plc_prg.sv
// ============================================================================
// Module   : plc_prg
// Purpose  : AUTO/MANUAL spindle-feed control with on-delay timer (TON).
//            Macro SHORT_TIMER_EN selects a 20-cycle default preset.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module plc_prg #(
`ifdef SHORT_TIMER_EN
  parameter int unsigned TON_PRESET = 20
`else
  parameter int unsigned TON_PRESET = 50_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned C_ACC_W  = 26;
  localparam logic [C_ACC_W-1:0] C_PRESET = C_ACC_W'(TON_PRESET);

  logic               w_start;
  logic               w_auto_sel;
  logic               w_man_sel;
  logic               w_auto_active;
  logic               w_man_active;
  logic               w_conflict;
  logic               w_run;
  logic               w_done;
  logic               w_control;
  logic               w_timing;
  logic [C_ACC_W-1:0] r_acc;

  assign w_start    = ui_in[0];
  assign w_auto_sel = ui_in[1];
  assign w_man_sel  = ui_in[2];

  // MAN wins when both selectors are asserted.
  assign w_man_active  = w_man_sel;
  assign w_auto_active = w_auto_sel & ~w_man_sel;
  assign w_conflict    = w_auto_sel & w_man_sel;
  assign w_run         = w_auto_active & w_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_run) begin
      if (r_acc < C_PRESET) begin
        r_acc <= r_acc + 1'b1;
      end
    end else begin
      r_acc <= '0;
    end
  end

  assign w_done   = (r_acc == C_PRESET);
  assign w_timing = w_run & ~w_done;

  always_comb begin
    w_control = 1'b0;
    if (w_man_active) begin
      w_control = w_start;
    end else if (w_auto_active) begin
      w_control = w_done;
    end
  end

  // Every driven output is gated by reset so the contactor drops immediately.
  always_comb begin
    uo_out = 8'h00;
    if (!rst) begin
      uo_out[0] = w_control;
      uo_out[1] = w_timing;
      uo_out[2] = w_auto_active;
      uo_out[3] = w_man_active;
      uo_out[4] = w_conflict;
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic w_unused;
  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

`default_nettype wire

// File: tb/tb_plc_prg.sv
// ============================================================================
// Module   : tb_plc_prg
// Purpose  : Directed bench for plc_prg with a run-length reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_plc_prg;

  localparam int unsigned P = 20;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;
  int run_len = 0;

  plc_prg #(.TON_PRESET(P)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: number of consecutive rising edges with AUTO-only and start high.
  always @(posedge clk or posedge rst) begin
    if (rst) run_len <= 0;
    else if (ui_in[1] && !ui_in[2] && ui_in[0]) run_len <= run_len + 1;
    else run_len <= 0;
  end

  function automatic logic [7:0] model_out();
    logic [7:0] e;
    logic s, a, m;
    e = 8'h00;
    s = ui_in[0]; a = ui_in[1]; m = ui_in[2];
    if (!rst) begin
      e[3] = m;
      e[2] = a & ~m;
      e[4] = a & m;
      if (m) e[0] = s;
      else if (a) e[0] = (run_len >= P);
      e[1] = a & ~m & s & (run_len < P);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    check("model_uo_out", uo_out, model_out());
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic auto_delay(input string name);
    for (int k = 1; k <= P + 2; k++) begin
      tick(1);
      check(name, uo_out, (k >= P) ? 8'h05 : 8'h06);
    end
  endtask

  initial begin
    ena = 1'b1;
    uio_in = 8'hA5;
    rst = 1'b1;
    ui_in = 8'hF3;   // start + AUTO, ignored bits set
    #1 check("reset_hold_a", uo_out, 8'h00);
    #25 check("reset_hold_b", uo_out, 8'h00);
    #24 check("reset_hold_c", uo_out, 8'h00);
    @(posedge clk); #3;
    rst = 1'b0;
    #1 check("after_release", uo_out, 8'h06);
    auto_delay("auto_after_reset");

    // Drop start: Control holds until the next edge, then falls.
    ui_in = 8'h02;
    #1 check("auto_drop_pre", uo_out, 8'h05);
    tick(1);
    check("auto_drop_post", uo_out, 8'h04);

    // Short pulse never reaches the preset and leaves the timer cleared.
    ui_in = 8'h03;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("short_pulse", uo_out, 8'h06);
    end
    ui_in = 8'h02;
    tick(1);
    check("short_pulse_end", uo_out, 8'h04);
    ui_in = 8'h03;
    auto_delay("auto_after_short");

    // AUTO -> MAN while done: MANUAL path takes over at once.
    ui_in = 8'h05;
    #1 check("auto_to_man", uo_out, 8'h09);
    tick(1);
    check("man_held", uo_out, 8'h09);
    // MAN -> AUTO with start held restarts the delay from zero.
    ui_in = 8'h03;
    #1 check("man_to_auto", uo_out, 8'h06);
    auto_delay("auto_restart");

    // MANUAL follows start combinationally.
    ui_in = 8'h04;
    #1 check("man_start_lo", uo_out, 8'h08);
    ui_in = 8'h05;
    #1 check("man_start_rise", uo_out, 8'h09);
    ui_in = 8'h04;
    #1 check("man_start_fall", uo_out, 8'h08);
    tick(2);

    // Both selectors: MAN priority, conflict flagged.
    ui_in = 8'h06;
    #1 check("conflict_idle", uo_out, 8'h18);
    ui_in = 8'h07;
    #1 check("conflict_start", uo_out, 8'h19);
    tick(2);
    check("conflict_held", uo_out, 8'h19);
    ui_in = 8'h06;
    #1 check("conflict_stop", uo_out, 8'h18);
    tick(1);

    // No mode selected.
    ui_in = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("no_mode", uo_out, 8'h00);
    end

    // Reset in the middle of a completed AUTO delay.
    ui_in = 8'h03;
    auto_delay("auto_before_rst");
    rst = 1'b1;
    #1 check("rst_mid_run", uo_out, 8'h00);
    tick(2);
    check("rst_mid_hold", uo_out, 8'h00);
    rst = 1'b0;
    auto_delay("auto_after_rst_mid");

    ui_in = 8'h00;
    tick(2);
    check("idle_end", uo_out, 8'h00);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
